// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion front end: direction indices,
// default keycodes and the keycode arbiter state type.
package ball_pkg;
    localparam int NUM_DIRS  = 4;
    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        DIR_W = 2'd0,
        DIR_S = 2'd1,
        DIR_A = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_t;

    localparam logic [7:0] KC_NONE = 8'h00;
    localparam logic [7:0] KC_W    = 8'h1A;
    localparam logic [7:0] KC_S    = 8'h16;
    localparam logic [7:0] KC_A    = 8'h04;
    localparam logic [7:0] KC_D    = 8'h07;

    // Bit index equals dir_t value, so the lowest set bit is the W>S>A>D winner.
    function automatic dir_t prio_pick(input logic [NUM_DIRS-1:0] v);
        dir_t r;
        r = DIR_D;
        if (v[DIR_A]) r = DIR_A;
        if (v[DIR_S]) r = DIR_S;
        if (v[DIR_W]) r = DIR_W;
        return r;
    endfunction
endpackage

// File: rtl/keycode_arbiter_if.sv
// Keycode word in, debounced direction keycode out.
interface keycode_arbiter_if;
    logic [31:0] keycodes;
    logic [7:0]  keycode;
    logic        key_valid;
    logic        press_pulse;

    modport master (output keycodes, input keycode, key_valid, press_pulse);
    modport slave  (input keycodes, output keycode, key_valid, press_pulse);
endinterface

// File: rtl/key_debounce.sv
// Single-direction saturating hold counter; reports acceptance using the
// post-edge count so acceptance lands on the edge the threshold is reached.
module key_debounce #(
    parameter int THRESH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic held,
    output logic stable,
    output logic new_stable
);
    localparam logic [3:0] TH = 4'(THRESH);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = 4'd0;
        if (held) cnt_d = (cnt_q >= TH) ? TH : cnt_q + 4'd1;
    end

    assign stable     = (cnt_d == TH);
    assign new_stable = stable && (cnt_q != TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keycode_arbiter.sv
// Turns the 4-slot HID keycode word into one debounced W/S/A/D keycode,
// tracking the most recent press and falling back to a still-held key.
module keycode_arbiter
    import ball_pkg::*;
#(
    parameter int         DEBOUNCE_FRAMES = 2,
    parameter logic [7:0] KEY_W           = KC_W,
    parameter logic [7:0] KEY_S           = KC_S,
    parameter logic [7:0] KEY_A           = KC_A,
    parameter logic [7:0] KEY_D           = KC_D
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    keycode_arbiter_if.slave   bus
);
    localparam logic [NUM_DIRS-1:0][7:0] DIR_CODES = {KEY_D, KEY_A, KEY_S, KEY_W};

    logic [NUM_DIRS-1:0] held, stable, new_stable;

    arb_state_t state_q, state_d;
    dir_t       act_q, act_d;
    logic [7:0] keycode_q, keycode_d;
    logic       valid_q, valid_d;
    logic       press_q, press_d;

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
        logic [NUM_SLOTS-1:0] hit;
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            assign hit[s] = (bus.keycodes[8*s +: 8] == DIR_CODES[d]);
        end
        assign held[d] = |hit;

        key_debounce #(.THRESH(DEBOUNCE_FRAMES)) u_deb (
            .clk        (frame_clk),
            .rst_n      (Reset_n),
            .held       (held[d]),
            .stable     (stable[d]),
            .new_stable (new_stable[d])
        );
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        press_d = 1'b0;
        if (|new_stable) begin
            // A fresh press outranks a same-edge release of the active key.
            state_d = ARB_ACTIVE;
            act_d   = prio_pick(new_stable);
            press_d = (state_q == ARB_IDLE) || (act_d != act_q);
        end else if (state_q == ARB_ACTIVE && !stable[act_q]) begin
            if (|stable) begin
                act_d   = prio_pick(stable);
                press_d = 1'b1;
            end else begin
                state_d = ARB_IDLE;
            end
        end
        valid_d   = (state_d == ARB_ACTIVE);
        keycode_d = valid_d ? DIR_CODES[act_d] : KC_NONE;
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ARB_IDLE;
            act_q     <= DIR_W;
            keycode_q <= KC_NONE;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            keycode_q <= keycode_d;
            valid_q   <= valid_d;
            press_q   <= press_d;
        end
    end

    assign bus.keycode     = keycode_q;
    assign bus.key_valid   = valid_q;
    assign bus.press_pulse = press_q;
endmodule
